seq_detect_param: RTL and testbench

//   Runtime-programmable serial bit-pattern detector; generalises the fixed 5-bit
//   10110 checker. Pattern length is 1..PAT_W and set at runtime. Overlapping or
//   non-overlapping match mode. Input valid qualifier. Saturating match counter.

---
 rtl/seq_detect_param.sv | 111 +++++++++++
 tb/tb_seq_detect_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector: 1..PAT_W bit pattern, optional
// overlapping matches, din qualifier, saturating match counter and cfg error pulse.
module seq_detect_param #(
  parameter int               PAT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 8'b0001_0110,
  parameter int               DEF_LEN     = 5,
  parameter bit               DEF_OVERLAP = 1'b1,
  parameter int               CNT_W       = 16,
  localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic             din,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             result,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  // Only PAT_W-1 history bits are stored; the incoming bit completes the window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             result_q, result_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] len_mask;
  logic             match;

  always_comb begin
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    result_d    = 1'b0;
    cfg_err_d   = 1'b0;
    match_cnt_d = match_cnt_q;
    match       = 1'b0;
    win         = {hist_q, din};

    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    if (cfg_we) begin
      if ((cfg_len != '0) && (cfg_len <= MAX_LEN)) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (din_vld) begin
      hist_d = win[PAT_W-2:0];
      fill_d = (fill_q == MAX_LEN) ? fill_q : fill_q + 1'b1;
      match  = (fill_d >= len_q) && (((win ^ pattern_q) & len_mask) == '0);
      if (match) begin
        result_d = 1'b1;
        // Non-overlap mode: the matched bits may not seed the next match.
        if (!overlap_q) fill_d = '0;
      end
    end

    if (cnt_clr) begin
      match_cnt_d = '0;
    end else if (match && !(&match_cnt_q)) begin
      match_cnt_d = match_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q   <= DEF_PATTERN;
      len_q       <= LEN_W'(DEF_LEN);
      overlap_q   <= DEF_OVERLAP;
      hist_q      <= '0;
      fill_q      <= '0;
      result_q    <= 1'b0;
      match_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      result_q    <= result_d;
      match_cnt_q <= match_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign result    = result_q;
  assign match_cnt = match_cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic, checked
// against a queue-based model; a 2-bit counter instance exercises saturation.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din_vld, din, cfg_we, cfg_overlap, cnt_clr;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             result, cfg_err, result2, cfg_err2;
  logic [15:0]      match_cnt;
  logic [1:0]       match_cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ov;
  bit               m_bits[$];
  int               m_cnt, m_cnt2;
  bit               exp_res, exp_err;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .result(result), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .result(result2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b0001_0110;
    m_len = 5;
    m_ov  = 1'b1;
    m_bits.delete();
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  task automatic check_outputs();
    chk("result", result, exp_res);
    chk("match_cnt", match_cnt, m_cnt);
    chk("cfg_err", cfg_err, exp_err);
    chk("result_c2", result2, exp_res);
    chk("match_cnt_c2", match_cnt2, m_cnt2);
  endtask

  // Drives one clock of inputs, advances the model, checks outputs after the edge.
  task automatic cycle(input logic vld, input logic d, input logic we,
                       input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic ov, input logic clr);
    bit hit;
    din_vld = vld; din = d; cfg_we = we; cfg_pattern = pat;
    cfg_len = len; cfg_overlap = ov; cnt_clr = clr;
    exp_res = 1'b0; exp_err = 1'b0; hit = 1'b0;
    if (we) begin
      if (len >= 1 && len <= PAT_W) begin
        m_pat = pat; m_len = int'(len); m_ov = ov; m_bits.delete();
      end else begin
        exp_err = 1'b1;
      end
    end else if (vld) begin
      m_bits.push_back(d);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        // Oldest of the last m_len bits must equal pattern[len-1].
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
      end
      if (hit) begin
        exp_res = 1'b1;
        if (!m_ov) m_bits.delete();
      end
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (hit) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic bit_in(input logic d);
    cycle(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic ov);
    cycle(1'b0, 1'b0, 1'b1, pat, len, ov, 1'b0);
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  // Reset pulse starting just after an edge; outputs checked while held.
  task automatic pulse_reset();
    din_vld = 0; din = 0; cfg_we = 0; cnt_clr = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0;
    rst_n = 1'b0;
    model_reset();
    exp_res = 1'b0; exp_err = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    din_vld = 0; din = 0; cfg_we = 0; cnt_clr = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // T1: reset values and default 10110 detection
    chk("t1_result", result, 0);
    chk("t1_cnt", match_cnt, 0);
    chk("t1_err", cfg_err, 0);
    rst_n = 1'b1;
    idle();
    feed(32'b10110, 5);
    chk("t1_default_hit", result, 1);

    // T2: overlapping defaults
    pulse_reset();
    feed(32'b10110110, 8);
    chk("t2_cnt", match_cnt, 2);

    // T3: non-overlap
    pulse_reset();
    cfg(8'b10110, 4'd5, 1'b0);
    feed(32'b10110110, 8);
    chk("t3_cnt", match_cnt, 1);

    // T4: short pattern with valid gaps, overlap then non-overlap
    for (int ov = 1; ov >= 0; ov--) begin
      pulse_reset();
      cfg(8'b101, 4'd3, 1'(ov));
      for (int i = 0; i < 5; i++) begin
        bit_in(1'(~i & 1));
        if (i < 4) begin idle(); idle(); end
      end
      chk(ov ? "t4_ov_cnt" : "t4_nov_cnt", match_cnt, ov ? 2 : 1);
    end

    // T5: reset mid-stream discards the partial match
    pulse_reset();
    feed(32'b1011, 4);
    pulse_reset();
    bit_in(1'b0);
    chk("t5_result", result, 0);
    chk("t5_cnt", match_cnt, 0);

    // T6: rejected configs, saturation, clear racing a match
    pulse_reset();
    feed(32'b10, 2);
    cfg(8'hFF, 4'd0, 1'b0);
    chk("t6_err_len0", cfg_err, 1);
    cfg(8'hFF, 4'd9, 1'b0);
    chk("t6_err_len9", cfg_err, 1);
    feed(32'b110, 3);
    chk("t6_old_cfg_hit", result, 1);
    for (int i = 0; i < 4; i++) feed(32'b110, 3);
    chk("t6_cnt16", match_cnt, 5);
    chk("t6_cnt2_sat", match_cnt2, 3);
    feed(32'b11, 2);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("t6_clr_result", result, 1);
    chk("t6_clr_cnt", match_cnt, 0);
    // Pattern bits above len are ignored
    cfg(8'b1111_0101, 4'd4, 1'b1);
    feed(32'b0101, 4);
    chk("t6_dontcare_hit", result, 1);

    // Random traffic with occasional reconfiguration and clears
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        logic [PAT_W-1:0] p;
        logic [LEN_W-1:0] l;
        p = PAT_W'($urandom);
        l = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(9, 15))
                                        : LEN_W'($urandom_range(0, 5));
        cycle(1'($urandom), 1'($urandom), 1'b1, p, l, 1'($urandom),
              ($urandom_range(0, 3) == 0));
      end else begin
        cycle(r < 75, 1'($urandom), 1'b0, PAT_W'($urandom), LEN_W'($urandom),
              1'($urandom), ($urandom_range(0, 99) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
